ro_pair_counter: RTL and testbench



---
 rtl/ro_pair_counter.sv | 144 ++++++++++++++
 tb/tb_ro_pair_counter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_pair_counter.sv
// Ring-oscillator pair edge counter: runs two ROs over a programmable window and
// compares their synchronized rising-edge counts into a single response bit.
module ro_pair_counter #(
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIN_W-1:0] i_win_len,
  input  logic             i_ro_a,
  input  logic             i_ro_b,
  output logic             o_ro_en,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_resp,
  output logic             o_tie,
  output logic             o_ovf,
  output logic [CNT_W-1:0] o_cnt_a,
  output logic [CNT_W-1:0] o_cnt_b
);

  localparam int ST_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    COUNT,
    COMPARE
  } state_t;

  state_t state, state_nxt;

  // [0],[1] = two-stage synchronizer, [2] = previous synchronized value
  logic [2:0]       a_sh, b_sh;
  logic             edge_a, edge_b;
  logic [ST_W-1:0]  settle_cnt;
  logic [WIN_W-1:0] win_rem;
  logic [CNT_W-1:0] cnt_a, cnt_b;
  logic             ovf_q;
  logic             accept;
  logic             settle_last;

  assign edge_a      = a_sh[1] & ~a_sh[2];
  assign edge_b      = b_sh[1] & ~b_sh[2];
  assign accept      = (state == IDLE) && i_start;
  assign settle_last = (settle_cnt == ST_W'(SETTLE_CYC - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    o_busy    = 1'b0;
    o_ro_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start) state_nxt = SETTLE;
      end
      SETTLE: begin
        o_busy  = 1'b1;
        o_ro_en = 1'b1;
        if (settle_last) state_nxt = (win_rem != '0) ? COUNT : COMPARE;
      end
      COUNT: begin
        o_busy  = 1'b1;
        o_ro_en = 1'b1;
        if (win_rem == WIN_W'(1)) state_nxt = COMPARE;
      end
      COMPARE: begin
        o_busy    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      settle_cnt <= '0;
      win_rem    <= '0;
      cnt_a      <= '0;
      cnt_b      <= '0;
      ovf_q      <= 1'b0;
      o_done     <= 1'b0;
      o_resp     <= 1'b0;
      o_tie      <= 1'b0;
      o_ovf      <= 1'b0;
      o_cnt_a    <= '0;
      o_cnt_b    <= '0;
    end else begin
      a_sh   <= {a_sh[1:0], i_ro_a};
      b_sh   <= {b_sh[1:0], i_ro_b};
      o_done <= (state == COMPARE);

      if (accept) begin
        settle_cnt <= '0;
        win_rem    <= i_win_len;
        cnt_a      <= '0;
        cnt_b      <= '0;
        ovf_q      <= 1'b0;
        o_resp     <= 1'b0;
        o_tie      <= 1'b0;
        o_ovf      <= 1'b0;
        o_cnt_a    <= '0;
        o_cnt_b    <= '0;
      end

      if (state == SETTLE) begin
        settle_cnt <= settle_cnt + 1'b1;
      end

      // Saturating counters; an increment attempted at full scale is recorded as overflow
      if (state == COUNT) begin
        win_rem <= win_rem - 1'b1;
        if (edge_a) begin
          if (cnt_a != '1) cnt_a <= cnt_a + 1'b1;
          else             ovf_q <= 1'b1;
        end
        if (edge_b) begin
          if (cnt_b != '1) cnt_b <= cnt_b + 1'b1;
          else             ovf_q <= 1'b1;
        end
      end

      if (state == COMPARE) begin
        o_cnt_a <= cnt_a;
        o_cnt_b <= cnt_b;
        o_resp  <= (cnt_a > cnt_b);
        o_tie   <= (cnt_a == cnt_b);
        o_ovf   <= ovf_q;
      end
    end
  end

endmodule

// File: tb/tb_ro_pair_counter.sv
// Scoreboard bench for ro_pair_counter: expected results are queued at start and
// compared when o_done fires; also covers window 0, ignored starts and mid-run reset.
module tb_ro_pair_counter;

  localparam int SETTLE = 8;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        start1 = 1'b0;
  logic        start2 = 1'b0;
  logic [15:0] win1   = '0;
  logic [15:0] win2   = '0;
  logic        ro_a   = 1'b0;
  logic        ro_b   = 1'b0;
  logic        ro_c   = 1'b0;

  logic        d1_ro_en, d1_busy, d1_done, d1_resp, d1_tie, d1_ovf;
  logic [15:0] d1_cnt_a, d1_cnt_b;
  logic        d2_ro_en, d2_busy, d2_done, d2_resp, d2_tie, d2_ovf;
  logic [7:0]  d2_cnt_a, d2_cnt_b;

  ro_pair_counter #(.CNT_W(16), .WIN_W(16), .SETTLE_CYC(SETTLE)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_win_len(win1),
    .i_ro_a(ro_a), .i_ro_b(ro_b), .o_ro_en(d1_ro_en), .o_busy(d1_busy),
    .o_done(d1_done), .o_resp(d1_resp), .o_tie(d1_tie), .o_ovf(d1_ovf),
    .o_cnt_a(d1_cnt_a), .o_cnt_b(d1_cnt_b)
  );

  ro_pair_counter #(.CNT_W(8), .WIN_W(16), .SETTLE_CYC(SETTLE)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_win_len(win2),
    .i_ro_a(ro_a), .i_ro_b(ro_c), .o_ro_en(d2_ro_en), .o_busy(d2_busy),
    .o_done(d2_done), .o_resp(d2_resp), .o_tie(d2_tie), .o_ovf(d2_ovf),
    .o_cnt_a(d2_cnt_a), .o_cnt_b(d2_cnt_b)
  );

  always #5 clk = ~clk;

  // RO half-periods; toggles fall on times ending in 2/7, never on a clock edge
  int ha = 20;
  int hb = 30;
  int hc = 50;
  initial begin #2; forever begin #(ha) ro_a = ~ro_a; end end
  initial begin #2; forever begin #(hb) ro_b = ~ro_b; end end
  initial begin #2; forever begin #(hc) ro_c = ~ro_c; end end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int unsigned a;
    int unsigned b;
    bit          resp;
    bit          tie;
    bit          ovf;
    int unsigned done_cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  function automatic exp_t mk_exp(input int unsigned a, input int unsigned b,
                                  input bit ovf, input int unsigned win);
    exp_t e;
    e.a        = a;
    e.b        = b;
    e.resp     = (a > b);
    e.tie      = (a == b);
    e.ovf      = ovf;
    e.done_cyc = cyc + SETTLE + win + 2;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && d1_done) begin
      if (q1.size() == 0) begin
        check("d1_unexpected_done", 1, 0);
      end else begin
        e = q1.pop_front();
        check("d1_cnt_a", d1_cnt_a, e.a);
        check("d1_cnt_b", d1_cnt_b, e.b);
        check("d1_resp", d1_resp, e.resp);
        check("d1_tie", d1_tie, e.tie);
        check("d1_ovf", d1_ovf, e.ovf);
        check("d1_done_cycle", cyc, e.done_cyc);
        check("d1_busy_at_done", d1_busy, 0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && d2_done) begin
      if (q2.size() == 0) begin
        check("d2_unexpected_done", 1, 0);
      end else begin
        e = q2.pop_front();
        check("d2_cnt_a", d2_cnt_a, e.a);
        check("d2_cnt_b", d2_cnt_b, e.b);
        check("d2_resp", d2_resp, e.resp);
        check("d2_tie", d2_tie, e.tie);
        check("d2_ovf", d2_ovf, e.ovf);
        check("d2_done_cycle", cyc, e.done_cyc);
      end
    end
  end

  task automatic go1(input int unsigned win, input int unsigned a, input int unsigned b, input bit ovf);
    @(negedge clk);
    win1   = 16'(win);
    start1 = 1'b1;
    q1.push_back(mk_exp(a, b, ovf, win));
    @(negedge clk);
    start1 = 1'b0;
    win1   = 16'hffff;
  endtask

  task automatic go2(input int unsigned win, input int unsigned a, input int unsigned b, input bit ovf);
    @(negedge clk);
    win2   = 16'(win);
    start2 = 1'b1;
    q2.push_back(mk_exp(a, b, ovf, win));
    @(negedge clk);
    start2 = 1'b0;
    win2   = 16'h0003;
  endtask

  task automatic wait1(input int unsigned budget);
    for (int i = 0; i < budget && q1.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (q1.size() != 0) begin
      check("d1_timeout", q1.size(), 0);
      q1.delete();
    end
  endtask

  task automatic wait2(input int unsigned budget);
    for (int i = 0; i < budget && q2.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (q2.size() != 0) begin
      check("d2_timeout", q2.size(), 0);
      q2.delete();
    end
  endtask

  task automatic check_d1_zero(input string pfx);
    check({pfx, "_busy"}, d1_busy, 0);
    check({pfx, "_ro_en"}, d1_ro_en, 0);
    check({pfx, "_done"}, d1_done, 0);
    check({pfx, "_resp"}, d1_resp, 0);
    check({pfx, "_tie"}, d1_tie, 0);
    check({pfx, "_ovf"}, d1_ovf, 0);
    check({pfx, "_cnt_a"}, d1_cnt_a, 0);
    check({pfx, "_cnt_b"}, d1_cnt_b, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_d1_zero("reset");
    check("reset_d2_cnt_a", d2_cnt_a, 0);
    rst_n = 1'b1;

    ha = 20; hb = 30;
    repeat (10) @(negedge clk);
    go1(600, 150, 100, 0);
    wait1(700);

    ha = 30; hb = 20;
    repeat (10) @(negedge clk);
    go1(600, 100, 150, 0);
    wait1(700);

    ha = 25; hb = 25;
    repeat (10) @(negedge clk);
    go1(500, 100, 100, 0);
    wait1(600);

    // Zero window: ro_en only for cycles 1..8, done at cycle 10
    @(negedge clk);
    win1   = '0;
    start1 = 1'b1;
    q1.push_back(mk_exp(0, 0, 0, 0));
    check("w0_ro_en_c0", d1_ro_en, 0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      check($sformatf("w0_ro_en_c%0d", k), d1_ro_en, (k <= 8) ? 1 : 0);
      check($sformatf("w0_busy_c%0d", k), d1_busy, (k <= 9) ? 1 : 0);
    end
    wait1(20);

    ha = 20; hc = 50;
    repeat (10) @(negedge clk);
    go2(2000, 255, 200, 1);
    wait2(2100);

    // Extra starts while busy must be ignored
    ha = 20; hb = 30;
    repeat (10) @(negedge clk);
    go1(600, 150, 100, 0);
    repeat (100) @(negedge clk);
    start1 = 1'b1; win1 = 16'd50;
    @(negedge clk);
    start1 = 1'b0;
    repeat (300) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait1(700);
    repeat (50) @(negedge clk);

    // Reset mid-COUNT aborts the run without a done pulse
    go1(600, 150, 100, 0);
    repeat (200) @(negedge clk);
    check("pre_rst_busy", d1_busy, 1);
    rst_n = 1'b0;
    #1;
    check_d1_zero("midrst");
    q1.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (700) @(negedge clk);
    check_d1_zero("post_rst_idle");

    go1(600, 150, 100, 0);
    wait1(700);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
